line_buf_loader: RTL and testbench

Parametrised successor to the single-line display buffer controller. On a trigger it fetches one line of `N_CHARS` characters from the character memory. The line lives at a selectable line index, and the memory read latency is configurable. Captured characters are presented as a flat parallel bus to the display renderer. It adds busy/done handshaking, queuing of one pending request, abort on enable loss and an optional atomic (double-buffered) update.

---
 rtl/line_buf_pkg.sv | 17 +
 rtl/rd_lat_pipe.sv | 39 +++
 rtl/line_buf_loader.sv | 151 +++++++++++++++
 tb/tb_line_buf_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and constants for the line buffer loader: FSM state encoding,
// read-latency bounds and the default base address of line 0.
package line_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  localparam logic [12:0] DEFAULT_BASE_ADDR = 13'h800;

endpackage

// File: rtl/rd_lat_pipe.sv
// Valid+index delay line matching the memory read latency. The flush input
// clears every stage so that reads already in flight are never captured.
module rd_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx
);

  logic [DEPTH-1:0] valid_q;
  logic [IDX_W-1:0] idx_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) idx_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      idx_q[0]   <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        idx_q[i]   <= idx_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_idx   = idx_q[DEPTH-1];

endmodule

// File: rtl/line_buf_loader.sv
// Fetches one N_CHARS-character line from character memory into a flat output bus.
// Define LINE_BUF_LOADER_DOUBLE_BUF_EN for an atomic (shadow-buffered) line update.
module line_buf_loader
  import line_buf_pkg::*;
#(
  parameter int                N_CHARS   = 100,
  parameter int                CHAR_W    = 8,
  parameter int                ADDR_W    = 13,
  parameter int                LINE_W    = 5,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                RD_LAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      trg,
  input  logic [LINE_W-1:0]         line_idx,
  input  logic [CHAR_W-1:0]         data_in,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_rd,
  output logic                      busy,
  output logic                      done,
  output logic [N_CHARS*CHAR_W-1:0] out
);

  localparam int K_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  state_t            state, state_nx;
  logic [K_W-1:0]    k_q, k_nx;
  logic [1:0]        drain_q, drain_nx;
  logic              pending_q, pending_nx;
  logic              start;
  logic [LINE_W-1:0] cur_line;
  logic              fetch;
  logic [ADDR_W-1:0] line_off;
  logic              cap_valid;
  logic [K_W-1:0]    cap_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k_q       <= '0;
      drain_q   <= '0;
      pending_q <= 1'b0;
      cur_line  <= '0;
    end else begin
      state     <= state_nx;
      k_q       <= k_nx;
      drain_q   <= drain_nx;
      pending_q <= pending_nx;
      if (start) cur_line <= line_idx;
    end
  end

  // Request handshake: trg is a level sampled every cycle. In IDLE it starts a
  // load; while busy it sets one pending request (extra trg pulses are absorbed),
  // which starts from IDLE right after COMMIT. done pulses for exactly one cycle
  // in COMMIT; busy covers FETCH..COMMIT. en low aborts and drops everything.
  always_comb begin
    state_nx   = state;
    k_nx       = k_q;
    drain_nx   = drain_q;
    pending_nx = pending_q;
    start      = 1'b0;
    if (!en) begin
      state_nx   = ST_IDLE;
      k_nx       = '0;
      drain_nx   = '0;
      pending_nx = 1'b0;
    end else begin
      if (state != ST_IDLE && trg) pending_nx = 1'b1;
      case (state)
        ST_IDLE: begin
          if (trg || pending_q) begin
            start      = 1'b1;
            state_nx   = ST_FETCH;
            k_nx       = '0;
            pending_nx = 1'b0;
          end
        end
        ST_FETCH: begin
          if (k_q == K_W'(N_CHARS - 1)) begin
            state_nx = ST_DRAIN;
            drain_nx = '0;
          end else begin
            k_nx = k_q + K_W'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_q == 2'(LAT - 1)) state_nx = ST_COMMIT;
          else                        drain_nx = drain_q + 2'd1;
        end
        ST_COMMIT: state_nx = ST_IDLE;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  // Address arithmetic deliberately wraps modulo 2^ADDR_W.
  assign fetch    = (state == ST_FETCH);
  assign line_off = ADDR_W'(cur_line * N_CHARS);
  assign mem_rd   = fetch;
  assign mem_addr = fetch ? (BASE_ADDR + line_off + ADDR_W'(k_q)) : '0;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_COMMIT);

  rd_lat_pipe #(
    .DEPTH (LAT),
    .IDX_W (K_W)
  ) u_rd_lat_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (~en),
    .in_valid  (fetch),
    .in_idx    (k_q),
    .out_valid (cap_valid),
    .out_idx   (cap_idx)
  );

  for (genvar g = 0; g < N_CHARS; g++) begin : g_slot
    logic              wr;
    logic [CHAR_W-1:0] slot_q;

    assign wr = cap_valid && (cap_idx == K_W'(g));

`ifdef LINE_BUF_LOADER_DOUBLE_BUF_EN
    logic [CHAR_W-1:0] shadow_q;

    // The visible slot only changes on COMMIT, so an aborted load never shows.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadow_q <= '0;
        slot_q   <= '0;
      end else begin
        if (wr)   shadow_q <= data_in;
        if (done) slot_q   <= shadow_q;
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     slot_q <= '0;
      else if (wr) slot_q <= data_in;
    end
`endif

    assign out[CHAR_W*g +: CHAR_W] = slot_q;
  end

endmodule

// File: tb/tb_line_buf_loader.sv
// Bench for line_buf_loader: two instances (RD_LAT=1 at 0x800, RD_LAT=3 at 0x1FF0)
// share directed stimulus; a cycle-timed model plus literal pins check both.
module tb_line_buf_loader;

  localparam int NC    = 100;
  localparam int CW    = 8;
  localparam int AW    = 13;
  localparam int LW    = 5;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [AW-1:0] BASE_A = 13'h800;
  localparam logic [AW-1:0] BASE_B = 13'h1FF0;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          trg = 1'b0;
  logic [LW-1:0] line_idx = '0;
  logic [CW-1:0] data_a = '0, data_b = '0;
  logic [AW-1:0] addr_a, addr_b;
  logic          rd_a, rd_b, busy_a, busy_b, done_a, done_b;
  logic [NC*CW-1:0] out_a, out_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  line_buf_loader #(
    .N_CHARS(NC), .CHAR_W(CW), .ADDR_W(AW), .LINE_W(LW), .BASE_ADDR(BASE_A), .RD_LAT(LAT_A)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .trg(trg), .line_idx(line_idx), .data_in(data_a),
    .mem_addr(addr_a), .mem_rd(rd_a), .busy(busy_a), .done(done_a), .out(out_a)
  );

  line_buf_loader #(
    .N_CHARS(NC), .CHAR_W(CW), .ADDR_W(AW), .LINE_W(LW), .BASE_ADDR(BASE_B), .RD_LAT(LAT_B)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .trg(trg), .line_idx(line_idx), .data_in(data_b),
    .mem_addr(addr_b), .mem_rd(rd_b), .busy(busy_b), .done(done_b), .out(out_b)
  );

  // ---------------- memory contents ----------------
  function automatic logic [CW-1:0] mem_val(input logic [AW-1:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hA5;
  endfunction

  logic [AW-1:0] ha [2][5];
  bit            hr [2][5];

  // Memory answers the address seen L cycles earlier; junk when no read was issued.
  always @(negedge clk) begin
    for (int j = 4; j > 0; j--) begin
      ha[0][j] = ha[0][j-1]; hr[0][j] = hr[0][j-1];
      ha[1][j] = ha[1][j-1]; hr[1][j] = hr[1][j-1];
    end
    ha[0][0] = addr_a; hr[0][0] = rd_a;
    ha[1][0] = addr_b; hr[1][0] = rd_b;
    data_a = hr[0][LAT_A] ? mem_val(ha[0][LAT_A]) : CW'($urandom);
    data_b = hr[1][LAT_B] ? mem_val(ha[1][LAT_B]) : CW'($urandom);
  end

  // ---------------- behavioural model ----------------
  bit            m_active [2];
  int            m_s      [2];
  logic [LW-1:0] m_line   [2];
  bit            m_pend   [2];
  logic [CW-1:0] m_out    [2][NC];
  logic [CW-1:0] m_shadow [2][NC];
  int            cap_due  [2][NC];
  logic [CW-1:0] cap_val  [2][NC];
  logic [31:0]   exp_q0[$];
  logic [31:0]   exp_q1[$];

  function automatic int lat(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic logic [AW-1:0] model_addr(input int i, input logic [LW-1:0] ln, input int k);
    int a;
    a = ((i == 0) ? int'(BASE_A) : int'(BASE_B)) + int'(ln) * NC + k;
    return AW'(a % 8192);
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic q_push(input int i, input int v);
    if (i == 0) exp_q0.push_back(32'(v)); else exp_q1.push_back(32'(v));
  endtask

  task automatic q_drop_last(input int i);
    if (i == 0) begin if (exp_q0.size() > 0) void'(exp_q0.pop_back()); end
    else begin if (exp_q1.size() > 0) void'(exp_q1.pop_back()); end
  endtask

  task automatic q_pop_front(input int i, output logic [31:0] v);
    if (i == 0) v = exp_q0.pop_front(); else v = exp_q1.pop_front();
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_active[i] = 0; m_s[i] = 0; m_line[i] = '0; m_pend[i] = 0;
      for (int k = 0; k < NC; k++) begin
        m_out[i][k] = '0; m_shadow[i][k] = '0; cap_due[i][k] = -1; cap_val[i][k] = '0;
      end
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // Advance instance i over cycle c using the inputs present during c.
  task automatic step_model(input int i, input int c);
    bit was;
    int off;
    was = m_active[i];
    off = c - m_s[i];
    for (int k = 0; k < NC; k++) begin
      if (cap_due[i][k] == c) begin
`ifdef LINE_BUF_LOADER_DOUBLE_BUF_EN
        m_shadow[i][k] = cap_val[i][k];
`else
        m_out[i][k] = cap_val[i][k];
`endif
        cap_due[i][k] = -1;
      end
    end
    if (was && off == NC + lat(i) + 1) begin
`ifdef LINE_BUF_LOADER_DOUBLE_BUF_EN
      for (int k = 0; k < NC; k++) m_out[i][k] = m_shadow[i][k];
`endif
      m_active[i] = 0;
    end
    if (!en) begin
      if (m_active[i]) begin
        m_active[i] = 0;
        q_drop_last(i);
      end
      m_pend[i] = 0;
      for (int k = 0; k < NC; k++) cap_due[i][k] = -1;
      return;
    end
    if (was && off >= 1 && off <= NC) begin
      cap_due[i][off-1] = c + lat(i);
      cap_val[i][off-1] = mem_val(model_addr(i, m_line[i], off - 1));
    end
    if (was) begin
      if (trg) m_pend[i] = 1;
    end else if (trg || m_pend[i]) begin
      m_active[i] = 1;
      m_s[i]      = c;
      m_line[i]   = line_idx;
      m_pend[i]   = 0;
      q_push(i, c + NC + lat(i) + 1);
    end
  endtask

  always @(posedge clk) begin
    if (rst) reset_model();
    else begin
      step_model(0, cyc);
      step_model(1, cyc);
    end
    cyc++;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_out(input string name, input logic [NC*CW-1:0] act, input logic [NC*CW-1:0] exp);
    int bad;
    bad = 0;
    checks++;
    if (act !== exp) begin
      for (int k = NC - 1; k >= 0; k--) if (act[k*CW +: CW] !== exp[k*CW +: CW]) bad = k;
      errors++;
      $display("FAIL %s: slot %0d got %0h expected %0h (cycle %0d)",
               name, bad, act[bad*CW +: CW], exp[bad*CW +: CW], cyc);
    end
  endtask

  task automatic compare_inst(input int i, input string p, input logic b, input logic d,
                              input logic r, input logic [AW-1:0] a, input logic [NC*CW-1:0] o);
    int               off;
    logic             e_r, e_d;
    logic [AW-1:0]    e_a;
    logic [NC*CW-1:0] e_o;
    logic [31:0]      front;
    off = cyc - m_s[i];
    e_r = m_active[i] && off >= 1 && off <= NC;
    e_d = m_active[i] && off == NC + lat(i) + 1;
    e_a = e_r ? model_addr(i, m_line[i], off - 1) : '0;
    for (int k = 0; k < NC; k++) e_o[k*CW +: CW] = m_out[i][k];
    chk({p, "_busy"},     32'(b), 32'(m_active[i]));
    chk({p, "_done"},     32'(d), 32'(e_d));
    chk({p, "_mem_rd"},   32'(r), 32'(e_r));
    chk({p, "_mem_addr"}, 32'(a), 32'(e_a));
    chk_out({p, "_out"}, o, e_o);
    if (d) begin
      if (q_size(i) == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_done_sb: done with no expected completion (cycle %0d)", p, cyc);
      end else begin
        q_pop_front(i, front);
        chk({p, "_done_sb"}, 32'(cyc), front);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      compare_inst(0, "a", busy_a, done_a, rd_a, addr_a, out_a);
      compare_inst(1, "b", busy_b, done_b, rd_b, addr_b, out_b);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_trg(input logic [LW-1:0] ln, output int t);
    line_idx = ln;
    trg      = 1'b1;
    t        = cyc;
    tick();
    trg      = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy_a && !busy_b) begin
        tick();
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_idle: still busy after %0d cycles (cycle %0d)", budget, cyc);
    tick();
  endtask

  task automatic chk_all_zero(input string p);
    chk({p, "_busy_a"}, 32'(busy_a), 32'h0);
    chk({p, "_done_a"}, 32'(done_a), 32'h0);
    chk({p, "_rd_a"},   32'(rd_a),   32'h0);
    chk({p, "_addr_a"}, 32'(addr_a), 32'h0);
    chk_out({p, "_out_a"}, out_a, '0);
    chk({p, "_busy_b"}, 32'(busy_b), 32'h0);
    chk({p, "_rd_b"},   32'(rd_b),   32'h0);
    chk({p, "_addr_b"}, 32'(addr_b), 32'h0);
    chk_out({p, "_out_b"}, out_b, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // Line 0: address range, wrap on the 0x1FF0 instance, completion timing.
    pulse_trg(5'd0, t);
    goto(t + 1);   @(negedge clk);
    chk("l0_a_first", 32'(addr_a), 32'h800);
    chk("l0_b_first", 32'(addr_b), 32'h1FF0);
    goto(t + 16);  @(negedge clk);
    chk("l0_b_k15", 32'(addr_b), 32'h1FFF);
    goto(t + 17);  @(negedge clk);
    chk("l0_b_k16_wrap", 32'(addr_b), 32'h0000);
    chk("l0_a_k16", 32'(addr_a), 32'h810);
    goto(t + 100); @(negedge clk);
    chk("l0_a_last", 32'(addr_a), 32'h863);
    goto(t + 101); @(negedge clk);
    chk("l0_a_drain_rd", 32'(rd_a), 32'h0);
    chk("l0_a_drain_busy", 32'(busy_a), 32'h1);
    goto(t + 102); @(negedge clk);
    chk("l0_a_done", 32'(done_a), 32'h1);
    goto(t + 103); @(negedge clk);
    chk("l0_a_idle_busy", 32'(busy_a), 32'h0);
    chk("l0_a_idle_done", 32'(done_a), 32'h0);
    goto(t + 104); @(negedge clk);
    chk("l0_b_done", 32'(done_b), 32'h1);
    goto(t + 106); @(negedge clk);
    chk("l0_a_slot0",  32'(out_a[0*CW +: CW]),  32'hAD);
    chk("l0_a_slot99", 32'(out_a[99*CW +: CW]), 32'hCE);
    chk("l0_b_slot15", 32'(out_b[15*CW +: CW]), 32'h45);
    chk("l0_b_slot16", 32'(out_b[16*CW +: CW]), 32'hA5);
    wait_idle(400);

    // Line 2 with two trg pulses mid-load: exactly one queued load of line 1.
    pulse_trg(5'd2, t);
    goto(t + 1);   @(negedge clk);
    chk("l2_a_first", 32'(addr_a), 32'h8C8);
    goto(t + 10);  trg = 1'b1; tick(); trg = 1'b0;
    goto(t + 20);  trg = 1'b1; tick(); trg = 1'b0;
    goto(t + 30);  line_idx = 5'd1;
    goto(t + 100); @(negedge clk);
    chk("l2_a_last", 32'(addr_a), 32'h92B);
    goto(t + 103); @(negedge clk);
    chk("pend_a_idle", 32'(busy_a), 32'h0);
    goto(t + 104); @(negedge clk);
    chk("pend_a_first", 32'(addr_a), 32'h864);
    chk("pend_a_rd", 32'(rd_a), 32'h1);
    goto(t + 106); @(negedge clk);
    chk("pend_b_first", 32'(addr_b), 32'h0054);
    wait_idle(400);
    repeat (20) tick();
    @(negedge clk);
    chk("no_third_a", 32'(busy_a), 32'h0);
    chk("no_third_b", 32'(busy_b), 32'h0);
    tick();

    // Line 3 aborted by dropping en for one cycle.
    pulse_trg(5'd3, t);
    goto(t + 51);  en = 1'b0;
    tick();        en = 1'b1;
    @(negedge clk);
    chk("abort_a_rd", 32'(rd_a), 32'h0);
    chk("abort_a_busy", 32'(busy_a), 32'h0);
    chk("abort_b_busy", 32'(busy_b), 32'h0);
    goto(t + 60);  @(negedge clk);
    chk("abort_a_stays_idle", 32'(busy_a), 32'h0);
    chk("abort_a_no_done", 32'(done_a), 32'h0);
`ifdef LINE_BUF_LOADER_DOUBLE_BUF_EN
    chk("abort_a_slot49", 32'(out_a[49*CW +: CW]), 32'h38);
`else
    chk("abort_a_slot49", 32'(out_a[49*CW +: CW]), 32'hF1);
`endif
    chk("abort_a_slot50", 32'(out_a[50*CW +: CW]), 32'h3B);
    tick();

    // Asynchronous reset in the middle of a load.
    pulse_trg(5'd4, t);
    goto(t + 30);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Recovery load of the last line.
    pulse_trg(5'd31, t);
    goto(t + 1);   @(negedge clk);
    chk("l31_a_first", 32'(addr_a), 32'h141C);
    chk("l31_b_first", 32'(addr_b), 32'h0C0C);
    wait_idle(400);
    repeat (5) tick();

    chk("sb_a_empty", 32'(exp_q0.size()), 32'h0);
    chk("sb_b_empty", 32'(exp_q1.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
